// File: rtl/vga_timing_gen.sv
// VGA raster timing source: free-running h/v counters with sync/blank decode and a sync delay line.
// Optional build macro VGA_FRAME_COUNT_EN adds frame_count, vblank_irq and vblank_ack.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 32'd640,
    parameter int unsigned H_FP       = 32'd16,
    parameter int unsigned H_SYNC     = 32'd96,
    parameter int unsigned H_BP       = 32'd48,
    parameter int unsigned V_ACTIVE   = 32'd480,
    parameter int unsigned V_FP       = 32'd10,
    parameter int unsigned V_SYNC     = 32'd2,
    parameter int unsigned V_BP       = 32'd33,
    parameter int unsigned SYNC_DELAY = 32'd2
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    input  logic       vblank_ack,
    output logic [15:0] frame_count,
    output logic       vblank_irq
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 32'd1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 32'd1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // {hs, vs, blank} as held by every delay stage while idle
    localparam logic [2:0] SYNC_IDLE = 3'b110;

    if ((H_TOTAL > 32'd1023) || (V_TOTAL > 32'd1023)) begin : g_bad_total
        $error("vga_timing_gen: timing totals exceed the 10-bit counter range");
    end
    if (SYNC_DELAY > 32'd4) begin : g_bad_delay
        $error("vga_timing_gen: SYNC_DELAY must be 0..4");
    end

    // Sync and blank decode of one counter position, packed {hs, vs, blank}
    function automatic logic [2:0] decode(input logic [9:0] h, input logic [9:0] v);
        logic hs_v;
        logic vs_v;
        logic blank_v;
        hs_v    = ~((h >= HS_START) && (h < HS_END));
        vs_v    = ~((v >= VS_START) && (v < VS_END));
        blank_v = (h < H_ACT) && (v < V_ACT);
        return {hs_v, vs_v, blank_v};
    endfunction

    logic [9:0] h_cnt_r;
    logic [9:0] v_cnt_r;
    logic [9:0] h_next_s;
    logic [9:0] v_next_s;
    logic       line_start_r;
    logic       frame_start_r;
    logic [2:0] cur_dec_r;

    // Next counter position; v advances only on the horizontal wrap
    always_comb begin
        h_next_s = h_cnt_r;
        v_next_s = v_cnt_r;
        if (h_cnt_r == H_LAST) begin
            h_next_s = 10'd0;
            if (v_cnt_r == V_LAST) begin
                v_next_s = 10'd0;
            end else begin
                v_next_s = v_cnt_r + 10'd1;
            end
        end else begin
            h_next_s = h_cnt_r + 10'd1;
        end
    end

    // Counters plus pulses and decode computed from the next position so they align with the counters
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            h_cnt_r       <= 10'd0;
            v_cnt_r       <= 10'd0;
            line_start_r  <= 1'b1;
            frame_start_r <= 1'b1;
            cur_dec_r     <= decode(10'd0, 10'd0);
        end else begin
            h_cnt_r       <= h_next_s;
            v_cnt_r       <= v_next_s;
            line_start_r  <= (h_next_s == 10'd0);
            frame_start_r <= (h_next_s == 10'd0) && (v_next_s == 10'd0);
            cur_dec_r     <= decode(h_next_s, v_next_s);
        end
    end

    assign DrawX       = h_cnt_r;
    assign DrawY       = v_cnt_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;

    // Shift-register delay so sync lines up with the renderers' pipelined RGB across wraps
    if (SYNC_DELAY == 32'd0) begin : g_no_delay
        assign {hs, vs, blank} = cur_dec_r;
    end else begin : g_delay
        for (genvar g = 0; g < int'(SYNC_DELAY); g++) begin : g_stage
            logic [2:0] q_r;
            if (g == 0) begin : g_first
                // First stage takes the current decode
                always_ff @(posedge vga_clk) begin
                    if (reset) begin
                        q_r <= SYNC_IDLE;
                    end else begin
                        q_r <= cur_dec_r;
                    end
                end
            end else begin : g_next
                // Later stages take the previous stage
                always_ff @(posedge vga_clk) begin
                    if (reset) begin
                        q_r <= SYNC_IDLE;
                    end else begin
                        q_r <= g_stage[g-1].q_r;
                    end
                end
            end
        end
        assign {hs, vs, blank} = g_stage[SYNC_DELAY-1].q_r;
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count_r;
    logic        vblank_irq_r;
    logic        frame_wrap_s;

    assign frame_wrap_s = (h_cnt_r == H_LAST) && (v_cnt_r == V_LAST);

    // Frame counter and sticky vblank flag; a set on the frame_start cycle beats a coincident ack
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            frame_count_r <= 16'd0;
            vblank_irq_r  <= 1'b0;
        end else begin
            if (frame_wrap_s) begin
                frame_count_r <= frame_count_r + 16'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
            if (frame_start_r) begin
                vblank_irq_r <= 1'b1;
            end else if (vblank_ack) begin
                vblank_irq_r <= 1'b0;
            end else begin
                vblank_irq_r <= vblank_irq_r;
            end
        end
    end

    assign frame_count = frame_count_r;
    assign vblank_irq  = vblank_irq_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default-timing instance plus a shrunken-timing instance with SYNC_DELAY=0.
module tb_vga_timing_gen;

    logic       clk;
    logic       rst_d;
    logic       rst_s;
    logic [9:0] draw_x_d, draw_y_d, draw_x_s, draw_y_s;
    logic       hs_d, vs_d, blank_d, ls_d, fs_d;
    logic       hs_s, vs_s, blank_s, ls_s, fs_s;
`ifdef VGA_FRAME_COUNT_EN
    logic        ack_d, ack_s, irq_d, irq_s;
    logic [15:0] fc_d, fc_s;
`endif

    int checks = 0;
    int errors = 0;
    int td = -1;     // cycles since the last reset edge, default instance
    int ts = -1;     // same for the small instance
    int phase = 0;
    int hs_low_cnt, blank_hi_cnt, vs_low_cnt;

    vga_timing_gen dut_d (
        .vga_clk(clk), .reset(rst_d), .DrawX(draw_x_d), .DrawY(draw_y_d),
        .hs(hs_d), .vs(vs_d), .blank(blank_d), .line_start(ls_d), .frame_start(fs_d)
`ifdef VGA_FRAME_COUNT_EN
        , .vblank_ack(ack_d), .frame_count(fc_d), .vblank_irq(irq_d)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(4), .SYNC_DELAY(0)
    ) dut_s (
        .vga_clk(clk), .reset(rst_s), .DrawX(draw_x_s), .DrawY(draw_y_s),
        .hs(hs_s), .vs(vs_s), .blank(blank_s), .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_FRAME_COUNT_EN
        , .vblank_ack(ack_s), .frame_count(fc_s), .vblank_irq(irq_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", nm, $time, act, exp);
        end
    endtask

    // {hs, vs, blank} from the timing rules for a raster position
    function automatic logic [2:0] rules(input int x, input int y, input int ha, input int hf,
                                         input int hw, input int va, input int vf, input int vw);
        logic h, v, b;
        h = !((x >= ha + hf) && (x < ha + hf + hw));
        v = !((y >= va + vf) && (y < va + vf + vw));
        b = (x < ha) && (y < va);
        return {h, v, b};
    endfunction

    // Model time: zeroed at every edge that samples reset, otherwise advances
    always @(posedge clk) begin
        if (rst_d) td = 0; else if (td >= 0) td = td + 1;
        if (rst_s) ts = 0; else if (ts >= 0) ts = ts + 1;
    end

`ifdef VGA_FRAME_COUNT_EN
    always @(negedge clk) begin
        ack_d = 1'b0;
        ack_s = (phase == 0) && (ts == 100 || ts == 1152);
    end
`endif

    // Compare process, default instance (800 x 525, delay 2)
    always @(negedge clk) begin : cmp_d
        int x, y;
        logic [2:0] e;
        if (td >= 0) begin
            x = td % 800;
            y = (td / 800) % 525;
            chk("d_drawx", 32'(draw_x_d), x);
            chk("d_drawy", 32'(draw_y_d), y);
            chk("d_line_start", 32'(ls_d), (x == 0) ? 1 : 0);
            chk("d_frame_start", 32'(fs_d), (x == 0 && y == 0) ? 1 : 0);
            if (td < 2) e = 3'b110;
            else e = rules((td - 2) % 800, ((td - 2) / 800) % 525, 640, 16, 96, 480, 10, 2);
            chk("d_hs", 32'(hs_d), 32'(e[2]));
            chk("d_vs", 32'(vs_d), 32'(e[1]));
            chk("d_blank", 32'(blank_d), 32'(e[0]));
`ifdef VGA_FRAME_COUNT_EN
            chk("d_frame_count", 32'(fc_d), 0);
            chk("d_irq", 32'(irq_d), (td >= 1) ? 1 : 0);
`endif
            if (td == 0) begin
                chk("d_lit_reset_fs", 32'(fs_d), 1);
                chk("d_lit_reset_hs", 32'(hs_d), 1);
                chk("d_lit_reset_blank", 32'(blank_d), 0);
            end
            if (td == 1) chk("d_lit_blank_t1", 32'(blank_d), 0);
            if (td == 2) chk("d_lit_blank_t2", 32'(blank_d), 1);
            if (td == 641) chk("d_lit_blank_last", 32'(blank_d), 1);
            if (td == 642) chk("d_lit_blank_off", 32'(blank_d), 0);
            if (td == 657) chk("d_lit_hs_before", 32'(hs_d), 1);
            if (td == 658) chk("d_lit_hs_first", 32'(hs_d), 0);
            if (td == 753) chk("d_lit_hs_last", 32'(hs_d), 0);
            if (td == 754) chk("d_lit_hs_after", 32'(hs_d), 1);
            if (td == 799) chk("d_lit_x799", 32'(draw_x_d), 799);
            if (td == 800) begin
                chk("d_lit_wrap_x", 32'(draw_x_d), 0);
                chk("d_lit_wrap_y", 32'(draw_y_d), 1);
            end
            if (td == 0) begin
                hs_low_cnt = 0;
                blank_hi_cnt = 0;
            end
            if (td == 801) begin
                chk("d_hs_low_len", hs_low_cnt, 96);
                chk("d_blank_hi_len", blank_hi_cnt, 640);
            end
            if (!hs_d) hs_low_cnt++;
            if (blank_d) blank_hi_cnt++;
        end
    end

    // Compare process, small instance (32 x 18, no delay)
    always @(negedge clk) begin : cmp_s
        int x, y;
        logic [2:0] e;
        if (ts >= 0) begin
            x = ts % 32;
            y = (ts / 32) % 18;
            e = rules(x, y, 16, 4, 6, 10, 2, 2);
            chk("s_drawx", 32'(draw_x_s), x);
            chk("s_drawy", 32'(draw_y_s), y);
            chk("s_line_start", 32'(ls_s), (x == 0) ? 1 : 0);
            chk("s_frame_start", 32'(fs_s), (x == 0 && y == 0) ? 1 : 0);
            chk("s_hs", 32'(hs_s), 32'(e[2]));
            chk("s_vs", 32'(vs_s), 32'(e[1]));
            chk("s_blank", 32'(blank_s), 32'(e[0]));
`ifdef VGA_FRAME_COUNT_EN
            chk("s_frame_count", 32'(fc_s), (ts / 576) % 65536);
            chk("s_irq", 32'(irq_s),
                ((ts >= 1) && !(phase == 0 && ts >= 101 && ts <= 576)) ? 1 : 0);
            if (ts == 1728) chk("s_lit_frame_count3", 32'(fc_s), 3);
            if (ts == 1153) chk("s_lit_irq_ack_coincide", 32'(irq_s), 1);
`endif
            if (ts == 0) begin
                chk("s_lit_reset_fs", 32'(fs_s), 1);
                chk("s_lit_reset_blank", 32'(blank_s), 1);
            end
            if (ts == 15) chk("s_lit_blank_last", 32'(blank_s), 1);
            if (ts == 16) chk("s_lit_blank_off", 32'(blank_s), 0);
            if (ts == 19) chk("s_lit_hs_before", 32'(hs_s), 1);
            if (ts == 20) chk("s_lit_hs_first", 32'(hs_s), 0);
            if (ts == 25) chk("s_lit_hs_last", 32'(hs_s), 0);
            if (ts == 26) chk("s_lit_hs_after", 32'(hs_s), 1);
            if (ts == 320) chk("s_lit_vblank_line", 32'(blank_s), 0);
            if (ts == 383) chk("s_lit_vs_before", 32'(vs_s), 1);
            if (ts == 384) chk("s_lit_vs_first", 32'(vs_s), 0);
            if (ts == 447) chk("s_lit_vs_last", 32'(vs_s), 0);
            if (ts == 448) chk("s_lit_vs_after", 32'(vs_s), 1);
            if (ts == 575) chk("s_lit_corner_y", 32'(draw_y_s), 17);
            if (ts == 0) vs_low_cnt = 0;
            if (ts == 576) begin
                chk("s_lit_frame_period", 32'(fs_s), 1);
                chk("s_vs_low_len", vs_low_cnt, 64);
            end
            if (!vs_s) vs_low_cnt++;
        end
    end

    initial begin
        rst_d = 1'b1;
        rst_s = 1'b1;
`ifdef VGA_FRAME_COUNT_EN
        ack_d = 1'b0;
        ack_s = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_d = 1'b0;
        rst_s = 1'b0;
        // default instance: one-clock reset at x=700, y=1, inside an hsync pulse
        repeat (1500) @(negedge clk);
        rst_d = 1'b1;
        @(negedge clk);
        rst_d = 1'b0;
        // small instance: one-clock reset at x=22, y=12 of frame 4, inside hsync and vsync
        repeat (633) @(negedge clk);
        rst_s = 1'b1;
        phase = 1;
        @(negedge clk);
        rst_s = 1'b0;
        repeat (700) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the VGA path: free-running horizontal/vertical counters on vga_clk produce DrawX/DrawY, hs, vs and blank.
- Sits directly upstream of the sprite/ROM renderers. They consume DrawX/DrawY/blank and register RGB after ROM and palette latency.
- Sync/blank outputs pass through a programmable delay so they line up at the pins with the renderers' pipelined RGB.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks); H_TOTAL = sum = 800
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
- SYNC_DELAY, 2, register stages applied to hs/vs/blank (legal 0..4); 2 matches ROM read plus RGB output register

Ports:
- vga_clk  input  1  pixel clock (25 MHz nominal)
- reset  input  1  synchronous, active-high reset
- DrawX  output  10  current horizontal count, 0..H_TOTAL-1
- DrawY  output  10  current vertical count, 0..V_TOTAL-1
- hs  output  1  horizontal sync, active low, delayed SYNC_DELAY clocks
- vs  output  1  vertical sync, active low, delayed SYNC_DELAY clocks
- blank  output  1  1 = display active (h<H_ACTIVE and v<V_ACTIVE), delayed SYNC_DELAY clocks
- line_start  output  1  one-cycle pulse while DrawX==0 (undelayed)
- frame_start  output  1  one-cycle pulse while DrawX==0 and DrawY==0 (undelayed)

Behaviour:
- Clocking: one clock (vga_clk). Reset is synchronous and active-high. All state updates on the rising vga_clk edge.
- Counters:
  - h_cnt increments every clock; at H_TOTAL-1 it wraps to 0.
  - v_cnt increments only on the h_cnt wrap; at V_TOTAL-1, on the h wrap, it wraps to 0.
  - DrawX = h_cnt and DrawY = v_cnt, driven directly from the counter registers with zero added latency.
- Decode (from counter values in the same cycle):
  - hs_raw = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults).
  - vs_raw = 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
  - blank_raw = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
- Delay line:
  - hs/vs/blank equal hs_raw/vs_raw/blank_raw from SYNC_DELAY clocks earlier.
  - With SYNC_DELAY=0 they are the decode of the current counters, with no register.
  - The delay is a shift register, not a counter offset, so it stays correct across wrap.
- Pulses: line_start and frame_start are decoded from the current counters with no delay. frame_start implies line_start.
- Reset:
  - Counters go to 0.
  - Every delay stage loads hs=1, vs=1, blank=0, so these outputs read 1/1/0 during reset and for SYNC_DELAY clocks after deassertion.
  - DrawX/DrawY read 0 in the first cycle after the reset edge, and frame_start is high in that cycle.
- Reset mid-frame: the next edge returns both counters to 0 regardless of position, and the delay line flushes to idle values. Partial sync pulses are truncated, never stretched.
- Simultaneous h and v wrap at (799,524): the next cycle is (0,0).
- Width: 10-bit counters suffice (max 799). Comparisons are unsigned. Parameter sums beyond 1023 are illegal; this is a synthesis-time assertion.
- No other handshake: this is a free-running source and downstream never back-pressures.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN.
- Defined:
  - Adds output frame_count [15:0], reset 0, incremented on the clock edge where the counters wrap from (H_TOTAL-1,V_TOTAL-1) to (0,0). It wraps 0xFFFF->0.
  - Adds output vblank_irq [1], a sticky flag set in the cycle frame_start asserts and cleared by input vblank_ack [1].
  - If ack and set coincide, set wins.
  - Both registers reset to 0.
- Undefined: the ports and registers are absent and all other behaviour is identical.

Test Plan:
- Reset held 3 clocks, then released -> first cycle DrawX=0, DrawY=0, frame_start=1, line_start=1; hs=1, vs=1, blank=0 for 2 clocks (SYNC_DELAY=2).
- Run one line -> DrawX steps 0..799 then 0; DrawY increments only at the 799->0 wrap. hs low exactly 96 clocks, first low at counter 656+2; blank high 640 clocks.
- Run full frame -> 525 lines, 420000 clocks between frame_start pulses. vs low for exactly 1600 clocks starting at line 490, pixel 2. blank low for all of lines 480..524.
- Assert reset at DrawX=300, DrawY=200 for 1 clock -> next cycle DrawX=0, DrawY=0, frame_start=1; delayed outputs read idle for 2 clocks, then resume correct decode.
- SYNC_DELAY=0 build -> hs/vs/blank transitions coincide with counter values 656/752, 490/492, 640 with no offset.
- VGA_FRAME_COUNT_EN build, 3 frames -> frame_count=3. vblank_irq set at each frame_start; vblank_ack pulsed together with frame_start -> vblank_irq stays 1.
